// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: DRP widths, controller states and the PLL reconfiguration profile tables.
package pll_cfg_pkg;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int ENTRIES = 4;
  localparam int IDX_W   = 2;
  typedef enum logic [2:0] {IDLE, RST_ASSERT, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } cfg_entry;
  // Masks keep the reserved/unrelated bits of each register from the read-back value.
  localparam cfg_entry PROFILE0 [ENTRIES] = '{
    '{7'h08, 16'h1000, 16'h0208},
    '{7'h09, 16'h8000, 16'h0000},
    '{7'h14, 16'h1000, 16'h0104},
    '{7'h15, 16'h8000, 16'h0000}
  };
  localparam cfg_entry PROFILE1 [ENTRIES] = '{
    '{7'h08, 16'h1000, 16'h0186},
    '{7'h09, 16'h8000, 16'h0000},
    '{7'h14, 16'h1000, 16'h0145},
    '{7'h15, 16'h8000, 16'h0080}
  };
endpackage

// File: rtl/pll_cfg_rom.sv
// pll_cfg_rom: combinational lookup of a profile table entry by {profile, index}.
module pll_cfg_rom import pll_cfg_pkg::*; (
  input  logic             i_profile,
  input  logic [IDX_W-1:0] i_index,
  output cfg_entry         o_entry
);
  assign o_entry = i_profile ? PROFILE1[i_index] : PROFILE0[i_index];
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: holds the PLL in reset, read-modify-writes a DRP profile, then waits for lock.
module pll_reconfig_ctrl import pll_cfg_pkg::*; #(
  parameter int NUM_WRITES   = 4,
  parameter int RST_HOLD     = 4,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_profile,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_clk_ok,
  output logic              o_pll_rst,
  input  logic              i_pll_locked,
  output logic [ADDR_W-1:0] o_daddr,
  output logic [DATA_W-1:0] o_di,
  input  logic [DATA_W-1:0] i_do,
  output logic              o_den,
  output logic              o_dwe,
  input  logic              i_drdy
);
  localparam logic [15:0] RST_LAST  = 16'(RST_HOLD - 1);
  localparam logic [15:0] DRP_LAST  = 16'(DRP_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WRITES - 1);
  state_t           r_state, w_next;
  logic [15:0]      r_cnt;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic             r_prof, w_prof, r_meta, r_lock_s, w_accept, w_timeout;
  cfg_entry         w_entry;
  // The ROM is addressed with next-cycle index/profile so outputs can be registered on state entry.
  pll_cfg_rom u_rom (.i_profile(w_prof), .i_index(w_idx), .o_entry(w_entry));
  assign w_accept = (r_state == IDLE) && i_start && !o_done;
  assign w_prof   = w_accept ? i_profile : r_prof;
  always_comb begin
    w_next    = r_state;
    w_idx     = r_idx;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:       if (w_accept) begin w_next = RST_ASSERT; w_idx = '0; end
      RST_ASSERT: if (r_cnt == RST_LAST) w_next = RD;
      RD:         w_next = RD_WAIT;
      RD_WAIT:    if (i_drdy) w_next = WR;
                  else if (r_cnt == DRP_LAST) begin w_next = IDLE; w_timeout = 1'b1; end
      WR:         w_next = WR_WAIT;
      WR_WAIT:    if (i_drdy) begin
                    w_next = (r_idx == IDX_LAST) ? LOCK_WAIT : RD;
                    w_idx  = (r_idx == IDX_LAST) ? r_idx : r_idx + IDX_W'(1);
                  end else if (r_cnt == DRP_LAST) begin w_next = IDLE; w_timeout = 1'b1; end
      LOCK_WAIT:  if (r_lock_s) w_next = IDLE;
                  else if (r_cnt == LOCK_LAST) begin w_next = IDLE; w_timeout = 1'b1; end
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_prof    <= 1'b0;
      r_meta    <= 1'b0;
      r_lock_s  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      o_clk_ok  <= 1'b0;
      o_pll_rst <= 1'b0;
      o_den     <= 1'b0;
      o_dwe     <= 1'b0;
      o_daddr   <= '0;
      o_di      <= '0;
    end else begin
      r_meta    <= i_pll_locked;
      r_lock_s  <= r_meta;
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
      r_idx     <= w_idx;
      r_prof    <= w_prof;
      o_busy    <= w_next != IDLE;
      o_done    <= (r_state == LOCK_WAIT) && r_lock_s;
      o_error   <= w_timeout || (o_error && !w_accept);
      o_clk_ok  <= r_lock_s && !o_busy;
      o_pll_rst <= w_next inside {RST_ASSERT, RD, RD_WAIT, WR, WR_WAIT};
      o_den     <= w_next inside {RD, WR};
      o_dwe     <= w_next == WR;
      if (w_next == RD) o_daddr <= w_entry.addr;
      if (r_state == RD_WAIT && i_drdy) o_di <= (i_do & w_entry.mask) | w_entry.data;
    end
  end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: randomized sequences against a table-driven scoreboard with DRP and PLL models.
module tb_pll_reconfig_ctrl;
  localparam int LOCK_TO = 100;
  localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;
  logic clk = 0, rst = 1, start = 0, prof = 0, locked = 0, drdy = 0;
  logic [15:0] dout = 0;
  logic busy, done, err, clk_ok, pll_rst, den, dwe;
  logic [6:0] daddr;
  logic [15:0] di;
  pll_reconfig_ctrl #(.NUM_WRITES(4), .RST_HOLD(4), .DRP_TIMEOUT(64), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_profile(prof), .o_busy(busy), .o_done(done),
    .o_error(err), .o_clk_ok(clk_ok), .o_pll_rst(pll_rst), .i_pll_locked(locked), .o_daddr(daddr),
    .o_di(di), .i_do(dout), .o_den(den), .o_dwe(dwe), .i_drdy(drdy));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  logic [6:0]  t_addr [2][4] = '{'{7'h08, 7'h09, 7'h14, 7'h15}, '{7'h08, 7'h09, 7'h14, 7'h15}};
  logic [15:0] t_mask [2][4] = '{'{16'h1000, 16'h8000, 16'h1000, 16'h8000}, '{16'h1000, 16'h8000, 16'h1000, 16'h8000}};
  logic [15:0] t_data [2][4] = '{'{16'h0208, 16'h0000, 16'h0104, 16'h0000}, '{16'h0186, 16'h0000, 16'h0145, 16'h0080}};
  typedef struct {int kind; logic [6:0] addr; logic [15:0] data;} exp_t;
  exp_t q[$];
  logic [15:0] rdv [128];
  int drp_lat = 3, stall_rd = -1, rd_num = 0, stall_cyc = -1, lock_delay = -1, lock_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [6:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int k, input logic [6:0] a, input logic [15:0] d);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_unexpected: got event kind %0d addr %0h di %0h, required no event", k, a, d);
      return;
    end
    e = q.pop_front();
    chk("sb_kind", k, e.kind);
    if (k <= K_WR) chk("sb_addr", a, e.addr);
    if (k == K_WR) chk("sb_wdata", d, e.data);
  endtask

  // DRP slave: answers each access after drp_lat cycles, optionally never answering one read.
  initial forever begin
    logic [6:0] a;
    logic w;
    bit skip;
    @(posedge clk); #1;
    drdy = 0;
    if (den && !rst) begin
      a = daddr; w = dwe; skip = 0;
      if (!w) begin
        skip = (rd_num == stall_rd);
        if (skip) stall_cyc = cyc;
        rd_num++;
      end
      if (!skip) begin
        repeat (drp_lat) @(posedge clk);
        #1;
        drdy = 1;
        dout = w ? 16'($urandom) : rdv[a];
      end
    end
  end

  // PLL: loses lock while in reset, relocks lock_delay cycles after release (never if negative).
  initial begin
    int lc;
    bit armed;
    lc = 0; armed = 0;
    forever begin
      @(posedge clk); #1;
      if (pll_rst) begin locked = 0; lc = 0; armed = 1; end
      else if (armed && lock_delay >= 0 && !locked) begin
        lc++;
        if (lc >= lock_delay) begin locked = 1; lock_cyc = cyc; end
      end
    end
  end

  // Monitor: every DRP access, done pulse and error rise must match the next expected event.
  initial begin
    bit err_q;
    err_q = 0;
    forever begin
      @(negedge clk);
      if (rst) err_q = 0;
      else begin
        if (den) pop_chk(dwe ? K_WR : K_RD, daddr, di);
        if (done) pop_chk(K_DONE, 7'h0, 16'h0);
        if (err && !err_q) pop_chk(K_ERR, 7'h0, 16'h0);
        err_q = err;
      end
    end
  end

  task automatic expect_seq(input bit p, input int stall, input bit exp_err);
    for (int i = 0; i < 4; i++) begin
      push(K_RD, t_addr[p][i], 16'h0);
      if (stall == i) break;
      push(K_WR, t_addr[p][i], (rdv[t_addr[p][i]] & t_mask[p][i]) | t_data[p][i]);
    end
    push(exp_err ? K_ERR : K_DONE, 7'h0, 16'h0);
  endtask

  task automatic run_seq(input bit p, input int lat, input int ld, input int stall, input bit ff, input bit poke);
    int s, guard, first_den, fall_cyc;
    bit prst_q, exp_err;
    drp_lat = lat; lock_delay = ld; stall_rd = stall; rd_num = 0; stall_cyc = -1; lock_cyc = -1;
    for (int a = 0; a < 128; a++) rdv[a] = ff ? 16'hFFFF : 16'($urandom);
    exp_err = (stall >= 0) || (ld < 0);
    expect_seq(p, stall, exp_err);
    @(posedge clk); #1;
    start = 1; prof = p; s = cyc;
    @(posedge clk); #1;
    start = 0;
    chk("busy_at_1", busy, 1);
    chk("pll_rst_at_1", pll_rst, 1);
    chk("error_cleared", err, 0);
    guard = 0; first_den = -1; fall_cyc = -1; prst_q = 1;
    while (busy && guard < 3000) begin
      if (den && first_den < 0) first_den = cyc;
      if (prst_q && !pll_rst && fall_cyc < 0) fall_cyc = cyc;
      prst_q = pll_rst;
      start = poke && (cyc == s + 12);
      if (poke && cyc == s + 12) prof = ~p;
      @(posedge clk); #1;
      guard++;
    end
    start = 0;
    chk("seq_in_budget", guard < 3000, 1);
    chk("first_den_cycle", first_den - s, 5);
    chk("done_pulse", done, !exp_err);
    chk("error_flag", err, exp_err);
    chk("pll_rst_low", pll_rst, 0);
    if (stall >= 0) chk("drp_timeout_cycle", cyc - stall_cyc, 65);
    else if (ld < 0) chk("lock_timeout_cycle", cyc - fall_cyc, LOCK_TO);
    else chk("done_after_lock", cyc - lock_cyc, 3);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("clk_ok", clk_ok, !exp_err);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
  endtask

  task automatic reset_test();
    int guard;
    bit seen;
    drp_lat = 3; lock_delay = 50; stall_rd = -1; rd_num = 0;
    for (int a = 0; a < 128; a++) rdv[a] = 16'($urandom);
    expect_seq(0, -1, 0);
    @(posedge clk); #1;
    start = 1; prof = 0;
    @(posedge clk); #1;
    start = 0; guard = 0;
    while (!(den && dwe) && guard < 500) begin @(posedge clk); #1; guard++; end
    chk("reached_write", guard < 500, 1);
    @(posedge clk); #1;
    rst = 1; q.delete();
    @(posedge clk); #1;
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", err, 0);
    chk("rst_pll_rst", pll_rst, 0);
    chk("rst_den", den, 0);
    chk("rst_dwe", dwe, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_di", di, 0);
    chk("rst_clk_ok", clk_ok, 0);
    seen = 0;
    repeat (10) begin @(posedge clk); #1; seen |= den | busy; end
    chk("no_activity_after_reset", seen, 0);
  endtask

  initial begin
    #500000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", err, 0);
    chk("reset_pll_rst", pll_rst, 0);
    chk("reset_den", den, 0);
    chk("reset_dwe", dwe, 0);
    chk("reset_daddr", daddr, 0);
    chk("reset_di", di, 0);
    chk("reset_clk_ok", clk_ok, 0);
    rst = 0;
    @(posedge clk); #2;
    drdy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_drdy_idle", busy | den, 0);
    run_seq(0, 3, 80, -1, 0, 0);
    run_seq(0, $urandom_range(1, 5), $urandom_range(5, 80), -1, 1, 0);
    for (int i = 0; i < 4; i++)
      run_seq(1'($urandom_range(0, 1)), $urandom_range(1, 5), $urandom_range(5, 80), -1, 0, 0);
    run_seq(0, 3, -1, 1, 0, 0);
    run_seq(1, 2, -1, -1, 0, 0);
    run_seq(1, 3, 40, -1, 0, 0);
    run_seq(0, 4, 30, -1, 0, 1);
    run_seq(1, 4, 30, -1, 0, 1);
    reset_test();
    repeat (60) @(posedge clk);
    run_seq(1, 2, 20, -1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
